uo_uart_tx: RTL

UO_UART_TX -- requirements
Module: uo_uart_tx

---
 rtl/uo_uart_pkg.sv | 26 ++
 rtl/uo_uart_fifo.sv | 58 +++++
 rtl/uo_uart_tx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uo_uart_pkg.sv
// Shared types and constants for the uo_uart_tx serializer.
// Optional parity bit is enabled by defining UO_UART_TX_PARITY_EN.
package uo_uart_pkg;

  localparam int   DATA_W    = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

`ifdef UO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4
  } uart_state_e;
`endif

endpackage

// File: rtl/uo_uart_fifo.sv
// Synchronous show-ahead FIFO with a registered occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module uo_uart_fifo
  import uo_uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uo_uart_tx.sv
// Buffered 8N1 UART transmitter for user-project bytes; define
// UO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uo_uart_tx
  import uo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [7:0] BIT_RELOAD = 8'(CLKS_PER_BIT - 1);

  uart_state_e       state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              bit_end;
  logic              can_start;

  // Ready comes from the registered count only, never from a same-cycle pop.
  assign in_ready  = !fifo_full && !rst;
  assign bit_end   = (cnt_q == 8'd0);
  assign can_start = !fifo_empty && ena;
  assign busy      = (state_q != ST_IDLE);

  uo_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid && in_ready),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= BIT_RELOAD;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? BIT_RELOAD : cnt_q - 8'd1;
    idx_d      = idx_q;
    data_d     = data_q;
    pop        = 1'b0;
    tx         = STOP_BIT;
    frame_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = BIT_RELOAD;
        if (can_start) begin
          pop     = 1'b1;
          data_d  = fifo_data;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx = START_BIT;
        if (bit_end) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx = data_q[idx_q];
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UO_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UO_UART_TX_PARITY_EN
      ST_PARITY: begin
        tx = ^data_q;
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        tx         = STOP_BIT;
        frame_done = bit_end;
        if (bit_end) begin
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (can_start) begin
            pop     = 1'b1;
            data_d  = fifo_data;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
